// File: rtl/dma_ctrl.sv
// dma_ctrl: block-copy DMA between the 6502 core and single-port system memory.
// Stalls the core via cpu_rdy, copies 1..256 bytes (length 0 = 256), then hands
// the bus back. While idle, memory is a transparent pass-through of the core bus.
// Build option: define DMA_DST_INC_EN for memory-to-memory copies (destination
// increments per byte); leave it undefined for memory-to-port copies where the
// destination stays fixed at the latched address.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | core owns the bus, waiting for start
// HALT  | core stalled, still owns the bus to finish an in-flight write
// RD    | DMA presents source address; data returns next cycle
// WR    | DMA writes returned byte to destination, advances pointers
// DONE  | one-cycle completion pulse, core already owns the bus again
module dma_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [7:0]  length,
  output logic        busy,
  output logic        done,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_wr_enable,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_rd_data,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wr_data,
  output logic        mem_wr_enable,
  input  logic [7:0]  mem_rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [8:0]  count_q;
  logic        busy_q;
  logic        done_q;
  logic        rdy_q;

  // Transfer sequencing; busy/done/cpu_rdy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      count_q <= 9'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            count_q <= (length == 8'd0) ? 9'd256 : {1'b0, length};
            state   <= S_HALT;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b0;
          end
        end
        S_HALT: begin
          // The core can only be halted on a read cycle.
          if (!cpu_wr_enable) begin
            state <= S_RD;
          end
        end
        S_RD: begin
          state <= S_WR;
        end
        S_WR: begin
          src_q   <= src_q + 16'd1;
`ifdef DMA_DST_INC_EN
          dst_q   <= dst_q + 16'd1;
`else
          dst_q   <= dst_q;
`endif
          count_q <= count_q - 9'd1;
          if (count_q == 9'd1) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            rdy_q  <= 1'b1;
          end else begin
            state <= S_RD;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          rdy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Bus mux: core passes through except during RD/WR, when the DMA drives memory.
  always_comb begin
    mem_address   = cpu_address;
    mem_wr_data   = cpu_wr_data;
    mem_wr_enable = cpu_wr_enable;
    case (state)
      S_RD: begin
        mem_address   = src_q;
        mem_wr_enable = 1'b0;
      end
      S_WR: begin
        mem_address   = dst_q;
        mem_wr_data   = mem_rd_data;
        mem_wr_enable = 1'b1;
      end
      default: begin
        mem_address   = cpu_address;
        mem_wr_data   = cpu_wr_data;
        mem_wr_enable = cpu_wr_enable;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign cpu_rdy     = rdy_q;
  assign cpu_rd_data = mem_rd_data;

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: directed plus randomized transfers checked against a byte-level
// copy model of system memory. Honours DMA_DST_INC_EN the same way as the design.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_enable;
  logic        cpu_rdy;
  logic [7:0]  cpu_rd_data;
  logic [15:0] mem_address;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_enable;
  logic [7:0]  mem_rd_data;

`ifdef DMA_DST_INC_EN
  localparam bit DST_INC = 1'b1;
`else
  localparam bit DST_INC = 1'b0;
`endif

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dma_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .cpu_address   (cpu_address),
    .cpu_wr_data   (cpu_wr_data),
    .cpu_wr_enable (cpu_wr_enable),
    .cpu_rdy       (cpu_rdy),
    .cpu_rd_data   (cpu_rd_data),
    .mem_address   (mem_address),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_enable (mem_wr_enable),
    .mem_rd_data   (mem_rd_data)
  );

  // Single-port synchronous memory: read data valid one cycle after address.
  always @(posedge clk) begin
    if (mem_wr_enable) mem[mem_address] <= mem_wr_data;
    mem_rd_data <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int diffs = 0;
    for (int a = 0; a < 65536; a++)
      if (mem[a] !== ref_mem[a]) diffs++;
    chk({tag, "_mem_diffs"}, 32'(diffs), 32'd0);
  endtask

  // One transfer. stall: extra cycles the core keeps writing after the start
  // cycle. stray: pulse start with junk config in the first WR. abort_rd: assert
  // reset during that RD ordinal (0 = run to completion).
  task automatic do_xfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                         input int stall, input bit stray, input int abort_rd, input string tag);
    int c;
    int n_exp;
    int abort_k;
    int busy_n = 0;
    int rdy_lo = 0;
    int done_n = 0;
    int done_k = -1;
    int first_wr = -1;
    bit finished = 0;
    logic [15:0] prev_addr = 16'h0000;
    logic [15:0] exp_wa[$];
    logic [7:0]  exp_wd[$];
    logic [15:0] exp_ra[$];
    logic [15:0] got_wa[$];
    logic [7:0]  got_wd[$];
    logic [15:0] got_ra[$];
    logic [15:0] core_a = 16'hC000 + 16'($urandom_range(0, 255));
    logic [7:0]  core_d = 8'($urandom);

    c       = (l == 8'd0) ? 256 : int'(l);
    n_exp   = (abort_rd > 0) ? abort_rd - 1 : c;
    abort_k = (abort_rd > 0) ? stall + 2 + 2 * (abort_rd - 1) : -1;

    if (stall > 0) ref_mem[core_a] = core_d;
    for (int i = 0; i < n_exp; i++) begin
      logic [15:0] ra;
      logic [15:0] wa;
      ra = s + 16'(i);
      wa = DST_INC ? d + 16'(i) : d;
      exp_ra.push_back(ra);
      exp_wa.push_back(wa);
      exp_wd.push_back(ref_mem[ra]);
      ref_mem[wa] = ref_mem[ra];
    end

    @(negedge clk);
    start         = 1'b1;
    src_addr      = s;
    dst_addr      = d;
    length        = l;
    cpu_address   = core_a;
    cpu_wr_data   = core_d;
    cpu_wr_enable = (stall > 0);
    @(posedge clk);

    for (int k = 1; k <= 2 * c + stall + 4; k++) begin
      @(negedge clk);
      start         = stray && (k == stall + 3);
      src_addr      = 16'($urandom);
      dst_addr      = 16'($urandom);
      length        = 8'($urandom);
      cpu_wr_enable = (k <= stall);
      resetn        = !(k == abort_k);
      #1;
      if (busy) busy_n++;
      if (!cpu_rdy) rdy_lo++;
      if (done) begin
        done_n++;
        done_k = k;
      end
      if (mem_wr_enable && !cpu_rdy && !cpu_wr_enable) begin
        got_wa.push_back(mem_address);
        got_wd.push_back(mem_wr_data);
        got_ra.push_back(prev_addr);
        if (first_wr < 0) first_wr = k;
      end
      prev_addr = mem_address;
      if (abort_k > 0 && k == abort_k + 1) begin
        chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
        chk({tag, "_abort_rdy"}, 32'(cpu_rdy), 32'd1);
        chk({tag, "_abort_we"}, 32'(mem_wr_enable), 32'd0);
        chk({tag, "_abort_done_n"}, 32'(done_n), 32'd0);
        finished = 1;
        break;
      end
      if (abort_k < 0 && done_k > 0 && k == done_k + 1) begin
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(cpu_rdy), 32'd1);
        finished = 1;
        break;
      end
    end
    start  = 1'b0;
    resetn = 1'b1;

    chk({tag, "_finished"}, 32'(finished), 32'd1);
    if (abort_k < 0) begin
      chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(2 * c + 2 + stall));
      chk({tag, "_rdy_low_cycles"}, 32'(rdy_lo), 32'(2 * c + 1 + stall));
      chk({tag, "_done_at"}, 32'(done_k), 32'(2 * c + 2 + stall));
      chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    end
    chk({tag, "_first_wr_at"}, 32'(first_wr), 32'(stall + 3));
    chk({tag, "_n_writes"}, 32'(got_wa.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < got_wa.size(); i++) begin
      chk($sformatf("%s_wa%0d", tag, i), 32'(got_wa[i]), 32'(exp_wa[i]));
      chk($sformatf("%s_wd%0d", tag, i), 32'(got_wd[i]), 32'(exp_wd[i]));
      chk($sformatf("%s_ra%0d", tag, i), 32'(got_ra[i]), 32'(exp_ra[i]));
    end
    chk_mem(tag);
  endtask

  initial begin
    logic [7:0] v;
    for (int a = 0; a < 65536; a++) begin
      v = 8'($urandom);
      mem[a]     = v;
      ref_mem[a] = v;
    end
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h11 * (i + 1));
      mem[16'h0200 + i]     = v;
      ref_mem[16'h0200 + i] = v;
    end

    resetn        = 1'b0;
    start         = 1'b0;
    src_addr      = 16'h0;
    dst_addr      = 16'h0;
    length        = 8'h0;
    cpu_address   = 16'h1234;
    cpu_wr_data   = 8'h5A;
    cpu_wr_enable = 1'b0;
    repeat (3) @(posedge clk);

    @(negedge clk);
    cpu_wr_enable = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_we_mirror", 32'(mem_wr_enable), 32'd1);
    chk("rst_addr_mirror", 32'(mem_address), 32'h1234);
    chk("rst_wd_mirror", 32'(mem_wr_data), 32'h5A);
    cpu_wr_enable = 1'b0;
    resetn        = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_we_mirror", 32'(mem_wr_enable), 32'd0);
    chk("idle_rd_data", 32'(cpu_rd_data), 32'(mem_rd_data));
    chk("idle_rdy", 32'(cpu_rdy), 32'd1);

    do_xfer(16'h0200, 16'h3000, 8'd4, 0, 1'b0, 0, "basic");
    chk("basic_3003", 32'(mem[16'h3000 + (DST_INC ? 3 : 0)]), 32'h44);
    do_xfer(16'h0400, 16'h5000, 8'd0, 0, 1'b0, 0, "full");
    do_xfer(16'h0600, 16'h3100, 8'd5, 2, 1'b0, 0, "stall");
    do_xfer(16'hFFFE, 16'h2100, 8'd3, 0, 1'b0, 0, "wrap");
    do_xfer(16'h0700, 16'h2004, 8'd4, 0, 1'b0, 0, "fixdst");
    do_xfer(16'h0800, 16'h3200, 8'd8, 0, 1'b1, 3, "abort");
    for (int t = 0; t < 6; t++)
      do_xfer(16'($urandom), 16'($urandom), 8'($urandom_range(1, 24)),
              int'($urandom_range(0, 3)), 1'($urandom), 0, $sformatf("rnd%0d", t));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
